// File: rtl/glow_xcr_pkg.sv
// Shared XCR-bus definitions for the timer responder: register offsets,
// CTRL/STAT bit positions and the default prescale-select width.
package glow_xcr_pkg;

  localparam int PS_W_DEF = 3;

  localparam logic [7:0] XCR_TMR_CTRL = 8'd0;
  localparam logic [7:0] XCR_TMR_STAT = 8'd1;
  localparam logic [7:0] XCR_TMR_RLDL = 8'd2;
  localparam logic [7:0] XCR_TMR_RLDH = 8'd3;
  localparam logic [7:0] XCR_TMR_CNTL = 8'd4;
  localparam logic [7:0] XCR_TMR_CNTH = 8'd5;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
  localparam int CTRL_PSEL = 3;

  localparam int STAT_OVF = 0;
  localparam int STAT_RUN = 1;

  // Offset is relative to the responder's base; wraps below base land far above CNTH.
  function automatic logic xcr_tmr_in_range(input logic [7:0] off);
    return off <= XCR_TMR_CNTH;
  endfunction

endpackage

// File: rtl/xcr_timer_if.sv
// XCR bus between the core (master) and one timer responder (slave).
// Protocol: XCRcs is the request valid; the responder is always ready, so a
// write commits on the edge where XCRcs & XCRwe, and read data is valid in the
// same cycle XCRcs & !XCRwe is presented (no wait states, no stall path).
interface xcr_timer_if;
  logic       XCRcs;
  logic       XCRwe;
  logic [7:0] XCRa;
  logic [7:0] XCRo;
  logic [7:0] XCRi;
  logic       irq;

  modport master (output XCRcs, output XCRwe, output XCRa, output XCRo,
                  input XCRi, input irq);
  modport slave  (input XCRcs, input XCRwe, input XCRa, input XCRo,
                  output XCRi, output irq);
endinterface

// File: rtl/xcr_tmr_prescaler.sv
// Prescaler for the XCR timer: emits one tick every 2**psel enabled cycles.
// clr restarts the count and swallows a tick that would land on the same edge.
module xcr_tmr_prescaler #(
    parameter int PS_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [PS_W-1:0] psel,
    input  logic            clr,
    output logic            tick
);

    localparam int PC_W = (1 << PS_W) - 1;
    localparam logic [PC_W-1:0] PC_ONE = 1;

    logic [PC_W-1:0] pcnt;
    logic [PC_W-1:0] limit;
    logic            at_max;

    assign limit  = ~({PC_W{1'b1}} << psel);
    assign at_max = (pcnt == limit);
    assign tick   = en & ~clr & at_max;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= at_max ? '0 : pcnt + PC_ONE;
        end
    end

endmodule

// File: rtl/xcr_timer.sv
// XCR-bus 16-bit down-counting timer with reload, one-shot mode, W1C overflow
// flag, coherent two-byte count read and a registered level interrupt.
module xcr_timer
    import glow_xcr_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h10,
    parameter int         PS_W      = PS_W_DEF
) (
    input logic        clk,
    input logic        rst,
    xcr_timer_if.slave xcr
);

    logic [7:0]      off;
    logic            hit, wr, rd;
    logic            wr_ctrl, wr_stat, wr_rldl, wr_rldh, rd_cntl;
    logic [PS_W-1:0] new_psel;
    logic            pre_clr, tick, zero, expire;

    logic            en, auto_rl, ie, ovf, irq_q;
    logic [PS_W-1:0] psel;
    logic [15:0]     rld, count;
    logic [7:0]      shadow;
    logic [7:0]      ctrl_rd, stat_rd, rdata;

    assign off      = xcr.XCRa - BASE_ADDR;
    assign hit      = xcr.XCRcs & xcr_tmr_in_range(off);
    assign wr       = hit & xcr.XCRwe;
    assign rd       = hit & ~xcr.XCRwe;
    assign wr_ctrl  = wr & (off == XCR_TMR_CTRL);
    assign wr_stat  = wr & (off == XCR_TMR_STAT);
    assign wr_rldl  = wr & (off == XCR_TMR_RLDL);
    assign wr_rldh  = wr & (off == XCR_TMR_RLDH);
    assign rd_cntl  = rd & (off == XCR_TMR_CNTL);
    assign new_psel = xcr.XCRo[CTRL_PSEL +: PS_W];

    // Restart the prescale phase on reload load, enable rising, or ratio change.
    assign pre_clr = wr_rldh |
                     (wr_ctrl & ((xcr.XCRo[CTRL_EN] & ~en) | (new_psel != psel)));

    xcr_tmr_prescaler #(.PS_W(PS_W)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .psel (psel),
        .clr  (pre_clr),
        .tick (tick)
    );

    assign zero   = (count == 16'd0);
    assign expire = tick & zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en      <= 1'b0;
            auto_rl <= 1'b0;
            ie      <= 1'b0;
            psel    <= '0;
            ovf     <= 1'b0;
            rld     <= '0;
            count   <= '0;
            shadow  <= '0;
            irq_q   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en      <= xcr.XCRo[CTRL_EN];
                auto_rl <= xcr.XCRo[CTRL_AUTO];
                ie      <= xcr.XCRo[CTRL_IE];
                psel    <= new_psel;
            end else if (expire && !auto_rl) begin
                en <= 1'b0;
            end

            // Hardware set is ordered after the W1C so it wins on a shared edge.
            if (wr_stat && xcr.XCRo[STAT_OVF]) ovf <= 1'b0;
            if (expire)                        ovf <= 1'b1;

            if (wr_rldl) rld[7:0]  <= xcr.XCRo;
            if (wr_rldh) rld[15:8] <= xcr.XCRo;

            if (wr_rldh) begin
                count <= {xcr.XCRo, rld[7:0]};
            end else if (tick) begin
                if (!zero)       count <= count - 16'd1;
                else if (auto_rl) count <= rld;
            end

            // Latch the high byte with the low-byte read so a 16-bit read is coherent.
            if (rd_cntl) shadow <= count[15:8];

            irq_q <= ie & ovf;
        end
    end

    always_comb begin
        ctrl_rd                       = '0;
        ctrl_rd[CTRL_EN]              = en;
        ctrl_rd[CTRL_AUTO]            = auto_rl;
        ctrl_rd[CTRL_IE]              = ie;
        ctrl_rd[CTRL_PSEL +: PS_W]    = psel;
        stat_rd                       = '0;
        stat_rd[STAT_OVF]             = ovf;
        stat_rd[STAT_RUN]             = en;
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            case (off)
                XCR_TMR_CTRL: rdata = ctrl_rd;
                XCR_TMR_STAT: rdata = stat_rd;
                XCR_TMR_RLDL: rdata = rld[7:0];
                XCR_TMR_RLDH: rdata = rld[15:8];
                XCR_TMR_CNTL: rdata = count[7:0];
                XCR_TMR_CNTH: rdata = shadow;
                default:      rdata = '0;
            endcase
        end
    end

    assign xcr.XCRi = rdata;
    assign xcr.irq  = irq_q;

endmodule

// File: tb/tb_xcr_timer.sv
// Self-checking bench for xcr_timer: directed scenarios plus randomized bus
// traffic, all checked against a register-level behavioural model.
module tb_xcr_timer;

  localparam logic [7:0] BASE = 8'h40;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  xcr_timer_if bus ();

  xcr_timer #(.BASE_ADDR(BASE), .PS_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .xcr (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_en, m_auto, m_ie, m_ovf, m_irq;
  int          m_psel, m_pre;
  int          m_rld, m_cnt, m_shadow;

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_ie = 0; m_ovf = 0; m_irq = 0;
    m_psel = 0; m_pre = 0; m_rld = 0; m_cnt = 0; m_shadow = 0;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] addr);
    logic [7:0] o;
    int v;
    o = addr - BASE;
    if (!bus.XCRcs || bus.XCRwe || o > 8'd5) return 8'h00;
    case (o)
      8'd0:    v = m_en + 2 * m_auto + 4 * m_ie + 8 * m_psel;
      8'd1:    v = m_ovf + 2 * m_en;
      8'd2:    v = m_rld % 256;
      8'd3:    v = m_rld / 256;
      8'd4:    v = m_cnt % 256;
      default: v = m_shadow;
    endcase
    return v[7:0];
  endfunction

  // Advance the model across one rising edge using the inputs currently on the bus.
  task automatic model_step();
    logic [7:0] o;
    int  d, period, n_pre, n_cnt, n_psel;
    bit  hit, wr, rd, rld_h, restart, tick, wrap, n_en, n_ovf;
    o      = bus.XCRa - BASE;
    d      = bus.XCRo;
    hit    = bus.XCRcs && (o <= 8'd5);
    wr     = hit && bus.XCRwe;
    rd     = hit && !bus.XCRwe;
    n_psel = (d / 8) % 8;
    period = 1 << m_psel;
    rld_h  = wr && o == 8'd3;
    restart = rld_h || (wr && o == 8'd0 && ((d % 2 == 1 && !m_en) || n_psel != m_psel));
    tick   = m_en && !restart && (m_pre == period - 1);
    wrap   = tick && m_cnt == 0;

    n_pre = restart ? 0 : (m_en ? (m_pre + 1) % period : m_pre);
    if (rld_h)     n_cnt = d * 256 + m_rld % 256;
    else if (tick) n_cnt = (m_cnt > 0) ? m_cnt - 1 : (m_auto ? m_rld : 0);
    else           n_cnt = m_cnt;
    n_ovf = wrap ? 1 : ((wr && o == 8'd1 && d % 2 == 1) ? 0 : m_ovf);
    n_en  = (wr && o == 8'd0) ? (d % 2 == 1) : ((wrap && !m_auto) ? 0 : m_en);

    m_irq = m_ie && m_ovf;
    if (rd && o == 8'd4) m_shadow = m_cnt / 256;
    if (wr && o == 8'd0) begin
      m_auto = (d / 2) % 2 == 1;
      m_ie   = (d / 4) % 2 == 1;
      m_psel = n_psel;
    end
    if (wr && o == 8'd2) m_rld = (m_rld / 256) * 256 + d;
    if (wr && o == 8'd3) m_rld = d * 256 + m_rld % 256;
    m_pre = n_pre; m_cnt = n_cnt; m_ovf = n_ovf; m_en = n_en;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clk_cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.irq !== m_irq) begin
      failures++;
      $display("FAIL irq_track: got %0b expected %0b at %0t", bus.irq, m_irq, $time);
    end
  endtask

  task automatic bus_idle();
    bus.XCRcs = 1'b0;
    bus.XCRwe = 1'b0;
    bus.XCRa  = 8'($urandom_range(0, 255));
    bus.XCRo  = 8'($urandom_range(0, 255));
  endtask

  task automatic idle(input int n);
    bus_idle();
    repeat (n) clk_cycle();
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    bus.XCRcs = 1'b1; bus.XCRwe = 1'b1; bus.XCRa = addr; bus.XCRo = data;
    clk_cycle();
    bus_idle();
  endtask

  task automatic wr(input int o, input logic [7:0] data);
    bus_write(BASE + 8'(o), data);
  endtask

  task automatic bus_read(input logic [7:0] addr, input string name, output logic [7:0] got);
    logic [7:0] exp;
    bus.XCRcs = 1'b1; bus.XCRwe = 1'b0; bus.XCRa = addr;
    bus.XCRo  = 8'($urandom_range(0, 255));
    #1;
    got = bus.XCRi;
    exp = model_read(addr);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
    clk_cycle();
    bus_idle();
  endtask

  task automatic rd_expect(input int o, input logic [7:0] exp, input string name);
    logic [7:0] got;
    bus_read(BASE + 8'(o), name, got);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s_const: got %02h expected %02h", name, got, exp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] got;
    rst = 1'b0;
    bus_idle();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++; $display("FAIL reset_irq: got %0b expected 0", bus.irq);
    end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) rd_expect(i, 8'h00, "reset_reg");
    // Run with an interrupt pending, then reset asynchronously mid-count.
    wr(2, 8'h01); wr(3, 8'h00); wr(0, 8'h07);
    idle(6);
    checks++;
    if (bus.irq !== 1'b1) begin
      failures++; $display("FAIL pre_reset_irq: got %0b expected 1", bus.irq);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++; $display("FAIL async_reset_irq: got %0b expected 0", bus.irq);
    end
    for (int i = 0; i < 6; i++) begin
      bus.XCRcs = 1'b1; bus.XCRwe = 1'b0; bus.XCRa = BASE + 8'(i);
      #1;
      checks++;
      if (bus.XCRi !== 8'h00) begin
        failures++; $display("FAIL async_reset_rd%0d: got %02h expected 00", i, bus.XCRi);
      end
    end
    bus_idle();
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) bus_read(BASE + 8'(i), "post_reset_rd", got);
  endtask

  task automatic test_decode();
    logic [7:0] got;
    bus_write(8'h3F, 8'hFF);
    bus_write(8'h46, 8'hFF);
    bus_read(8'h3F, "decode_below", got);
    bus_read(8'h46, "decode_above", got);
    for (int i = 0; i < 6; i++) rd_expect(i, 8'h00, "decode_no_effect");
  endtask

  task automatic test_periodic();
    logic [7:0] exp_cnt [5];
    exp_cnt = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
    wr(2, 8'h03); wr(3, 8'h00); wr(0, 8'h07);
    bus.XCRcs = 1'b0; bus.XCRwe = 1'b0; bus.XCRa = BASE;
    #1;
    checks++;
    if (bus.XCRi !== 8'h00) begin
      failures++; $display("FAIL rd_no_cs: got %02h expected 00", bus.XCRi);
    end
    bus.XCRcs = 1'b1; bus.XCRwe = 1'b1; bus.XCRo = 8'h07;
    #1;
    checks++;
    if (bus.XCRi !== 8'h00) begin
      failures++; $display("FAIL rd_during_write: got %02h expected 00", bus.XCRi);
    end
    bus_idle();
    for (int i = 0; i < 5; i++) begin
      rd_expect(4, exp_cnt[i], "periodic_cnt");
      if (i == 3) begin
        checks++;
        if (bus.irq !== 1'b0) begin
          failures++; $display("FAIL irq_early: got %0b expected 0", bus.irq);
        end
      end
    end
    checks++;
    if (bus.irq !== 1'b1) begin
      failures++; $display("FAIL irq_rise: got %0b expected 1", bus.irq);
    end
    wr(1, 8'h01);
    checks++;
    if (bus.irq !== 1'b1) begin
      failures++; $display("FAIL irq_hold: got %0b expected 1", bus.irq);
    end
    idle(1);
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++; $display("FAIL irq_clear: got %0b expected 0", bus.irq);
    end
    wr(0, 8'h00); wr(1, 8'h01); idle(1);
  endtask

  task automatic test_oneshot();
    wr(2, 8'h02); wr(3, 8'h00); wr(0, 8'h11);
    idle(11);
    rd_expect(1, 8'h02, "oneshot_running");
    rd_expect(1, 8'h01, "oneshot_stat");
    rd_expect(4, 8'h00, "oneshot_cnt");
    idle(8);
    rd_expect(4, 8'h00, "oneshot_cnt_stays");
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++; $display("FAIL oneshot_irq: got %0b expected 0", bus.irq);
    end
    wr(1, 8'h01);
  endtask

  task automatic test_coherency();
    wr(2, 8'hFF); wr(3, 8'h01); wr(0, 8'h01);
    rd_expect(4, 8'hFF, "coh_cntl");
    idle(300);
    rd_expect(5, 8'h01, "coh_cnth_shadow");
    rd_expect(4, 8'hD1, "coh_cntl_later");
    rd_expect(5, 8'h00, "coh_cnth_new");
    wr(0, 8'h00);
  endtask

  task automatic test_collision();
    wr(2, 8'h02); wr(3, 8'h00); wr(0, 8'h03);
    idle(2);
    wr(1, 8'h01);
    rd_expect(1, 8'h03, "w1c_vs_set");
    wr(2, 8'h34);
    wr(3, 8'h12);
    rd_expect(4, 8'h34, "rldh_beats_tick");
    rd_expect(5, 8'h12, "rldh_shadow");
    wr(0, 8'h00); wr(1, 8'h01);
    rd_expect(1, 8'h00, "collision_cleanup");
  endtask

  task automatic test_random();
    logic [7:0] got, d;
    int r, o;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      o = $urandom_range(0, 5);
      if (r < 4) begin
        d = 8'($urandom_range(0, 255));
        if (o == 3) d = 8'($urandom_range(0, 1));
        if (o == 0) d = {2'b00, 1'b0, d[4:0]};
        if ($urandom_range(0, 15) == 0) bus_write(BASE + 8'($urandom_range(6, 250)), d);
        else wr(o, d);
      end else if (r < 8) begin
        bus_read(BASE + 8'(o), "random_rd", got);
      end else begin
        idle($urandom_range(1, 4));
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    test_reset();
    test_decode();
    test_periodic();
    test_oneshot();
    test_coherency();
    test_collision();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
